// File: rtl/ps2_key_matrix_if.sv
// Byte-receiver handshake and map-table write port of the PS/2 key matrix engine.
// The decoder instance uses the slave modport; whoever feeds bytes and programs the map uses master.
interface ps2_key_matrix_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  localparam int unsigned WW = 2 + $clog2(ROWS) + $clog2(COLS);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          map_we;
  logic [8:0]    map_addr;
  logic [WW-1:0] map_wdata;
  logic          init_busy;

  modport master (
    output rx_valid, rx_data, map_we, map_addr, map_wdata,
    input  rx_ready, init_busy
  );

  modport slave (
    input  rx_valid, rx_data, map_we, map_addr, map_wdata,
    output rx_ready, init_busy
  );
endinterface

// File: rtl/ps2_key_matrix.sv
// PS/2 set-2 scancode decoder driving a row-selectable key matrix and modifier bits through a
// runtime-writable 512-entry {ext, code} map table.
module ps2_key_matrix #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned NMOD       = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  ps2_key_matrix_if.slave     bus,
  input  logic [ROWS-1:0]     sel,
  output logic [COLS-1:0]     odata,
  output logic [NMOD-1:0]     mods,
  output logic                key_event,
  output logic [8:0]          key_code,
  output logic                key_make
);
  localparam int unsigned RB = $clog2(ROWS);
  localparam int unsigned CB = $clog2(COLS);
  localparam int unsigned WW = 2 + RB + CB;

  typedef enum logic [2:0] {
    StInit, StIdle, StExt, StBrk, StExtBrk, StSkip, StLookup, StApply
  } state_e;

  state_e                     state_q, state_d;
  logic [8:0]                 init_cnt_q, init_cnt_d;
  logic [2:0]                 skip_q, skip_d;
  logic [8:0]                 pend_code_q, pend_code_d;
  logic                       pend_make_q, pend_make_d;
  logic [ROWS-1:0][COLS-1:0]  matrix_q, matrix_d;
  logic [NMOD-1:0]            mods_q, mods_d;
  logic                       key_event_q, key_event_d;
  logic [8:0]                 key_code_q, key_code_d;
  logic                       key_make_q, key_make_d;

  logic [WW-1:0]              table_mem [512];
  logic [WW-1:0]              entry_q;
  logic                       tbl_we;
  logic [8:0]                 tbl_waddr;
  logic [WW-1:0]              tbl_wdata;

  logic                       accept;
  logic [7:0]                 rx_byte;
  logic [1:0]                 kind;
  logic [RB-1:0]              row;
  logic [CB-1:0]              col;
  logic [COLS-1:0]            row_or;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  assign bus.rx_ready  = (state_q == StIdle) || (state_q == StExt) || (state_q == StBrk) ||
                         (state_q == StExtBrk) || (state_q == StSkip);
  assign bus.init_busy = (state_q == StInit);
  assign accept        = bus.rx_valid & bus.rx_ready;
  assign rx_byte       = bus.rx_data;

  assign kind = entry_q[WW-1 -: 2];
  assign row  = entry_q[CB +: RB];
  assign col  = entry_q[CB-1:0];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    skip_d      = skip_q;
    pend_code_d = pend_code_q;
    pend_make_d = pend_make_q;
    matrix_d    = matrix_q;
    mods_d      = mods_q;
    key_event_d = 1'b0;
    key_code_d  = key_code_q;
    key_make_d  = key_make_q;

    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 9'd1;
        if (init_cnt_q == 9'd511) state_d = StIdle;
      end
      StIdle: begin
        if (accept) begin
          case (rx_byte)
            8'hE0: state_d = StExt;
            8'hF0: state_d = StBrk;
            8'hE1: begin
              skip_d  = 3'd7;
              state_d = StSkip;
            end
            // BAT completion or keyboard overrun: nothing can be trusted to be held any more.
            8'hAA, 8'hFC, 8'h00, 8'hFF: begin
              matrix_d = '0;
              mods_d   = '0;
            end
            8'hFA, 8'hFE: ;
            default: begin
              pend_code_d = {1'b0, rx_byte};
              pend_make_d = 1'b1;
              state_d     = StLookup;
            end
          endcase
        end
      end
      StExt: begin
        if (accept) begin
          if (rx_byte == 8'hF0) begin
            state_d = StExtBrk;
          end else if (is_fake_shift(rx_byte)) begin
            state_d = StIdle;
          end else begin
            pend_code_d = {1'b1, rx_byte};
            pend_make_d = 1'b1;
            state_d     = StLookup;
          end
        end
      end
      StBrk: begin
        if (accept) begin
          pend_code_d = {1'b0, rx_byte};
          pend_make_d = 1'b0;
          state_d     = StLookup;
        end
      end
      StExtBrk: begin
        if (accept) begin
          if (is_fake_shift(rx_byte)) begin
            state_d = StIdle;
          end else begin
            pend_code_d = {1'b1, rx_byte};
            pend_make_d = 1'b0;
            state_d     = StLookup;
          end
        end
      end
      StSkip: begin
        // Pause (E1 ...) has no break code; swallow its remaining seven bytes.
        if (accept) begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = StIdle;
        end
      end
      StLookup: state_d = StApply;
      StApply: begin
        key_event_d = 1'b1;
        key_code_d  = pend_code_q;
        key_make_d  = pend_make_q;
        case (kind)
          2'b01: matrix_d[row][col] = pend_make_q;
          2'b10: begin
            for (int unsigned m = 0; m < NMOD; m++) begin
              if (col == CB'(m)) mods_d[m] = pend_make_q;
            end
          end
          default: ;
        endcase
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      skip_q      <= '0;
      pend_code_q <= '0;
      pend_make_q <= 1'b0;
      matrix_q    <= '0;
      mods_q      <= '0;
      key_event_q <= 1'b0;
      key_code_q  <= '0;
      key_make_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      skip_q      <= skip_d;
      pend_code_q <= pend_code_d;
      pend_make_q <= pend_make_d;
      matrix_q    <= matrix_d;
      mods_q      <= mods_d;
      key_event_q <= key_event_d;
      key_code_q  <= key_code_d;
      key_make_q  <= key_make_d;
    end
  end

  // Clearing owns the write port during INIT; host writes are dropped there.
  always_comb begin
    tbl_we    = bus.map_we;
    tbl_waddr = bus.map_addr;
    tbl_wdata = bus.map_wdata;
    if (state_q == StInit) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_cnt_q;
      tbl_wdata = '0;
    end
  end

  // Read and write share an edge, so a same-address write during LOOKUP yields the old entry.
  always_ff @(posedge clk) begin
    if (tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
    if (state_q == StLookup) entry_q <= table_mem[pend_code_q];
  end

  always_comb begin
    row_or = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (sel[r] != ACTIVE_LOW) row_or = row_or | matrix_q[r];
    end
    odata = row_or ^ {COLS{ACTIVE_LOW}};
  end

  assign mods      = mods_q ^ {NMOD{ACTIVE_LOW}};
  assign key_event = key_event_q;
  assign key_code  = key_code_q;
  assign key_make  = key_make_q;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Randomized self-checking bench for ps2_key_matrix; an active-high and an active-low instance
// share the stimulus and are compared against a byte-stream reference model.
module tb_ps2_key_matrix;
  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;
  localparam int unsigned NMOD = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_key_matrix_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  ps2_key_matrix_if #(.ROWS(ROWS), .COLS(COLS)) bus_al ();

  assign bus_al.rx_valid  = bus.rx_valid;
  assign bus_al.rx_data   = bus.rx_data;
  assign bus_al.map_we    = bus.map_we;
  assign bus_al.map_addr  = bus.map_addr;
  assign bus_al.map_wdata = bus.map_wdata;

  logic [ROWS-1:0] sel;
  logic [COLS-1:0] odata, odata_al;
  logic [NMOD-1:0] mods, mods_al;
  logic            key_event, key_event_al;
  logic [8:0]      key_code, key_code_al;
  logic            key_make, key_make_al;

  ps2_key_matrix #(.ROWS(ROWS), .COLS(COLS), .NMOD(NMOD), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sel(sel), .odata(odata), .mods(mods),
    .key_event(key_event), .key_code(key_code), .key_make(key_make)
  );

  ps2_key_matrix #(.ROWS(ROWS), .COLS(COLS), .NMOD(NMOD), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .bus(bus_al), .sel(sel), .odata(odata_al), .mods(mods_al),
    .key_event(key_event_al), .key_code(key_code_al), .key_make(key_make_al)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [1:0]      m_kind [512];
  int              m_row  [512];
  int              m_col  [512];
  logic [COLS-1:0] m_mat  [ROWS];
  logic [NMOD-1:0] m_mods;
  logic [7:0]      seq [$];
  int              skip_left;
  logic [9:0]      exp_q [$];

  task automatic model_reset();
    seq.delete();
    exp_q.delete();
    skip_left = 0;
    m_mods    = '0;
    for (int r = 0; r < ROWS; r++) m_mat[r] = '0;
    for (int a = 0; a < 512; a++) begin
      m_kind[a] = 2'b00;
      m_row[a]  = 0;
      m_col[a]  = 0;
    end
  endtask

  task automatic model_event(input bit ext, input logic [7:0] code, input bit make);
    int a;
    a = {ext, code};
    exp_q.push_back({make, ext, code});
    if (m_kind[a] == 2'b01) m_mat[m_row[a]][m_col[a]] = make;
    else if (m_kind[a] == 2'b10 && m_col[a] < NMOD) m_mods[m_col[a]] = make;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit brk;
    if (skip_left > 0) begin
      skip_left--;
      return;
    end
    seq.push_back(b);
    if (seq.size() == 1) begin
      if (b == 8'hE0 || b == 8'hF0) return;
      seq.delete();
      if (b == 8'hE1) skip_left = 7;
      else if (b inside {8'hAA, 8'hFC, 8'h00, 8'hFF}) begin
        m_mods = '0;
        for (int r = 0; r < ROWS; r++) m_mat[r] = '0;
      end else if (!(b inside {8'hFA, 8'hFE})) model_event(1'b0, b, 1'b1);
    end else if (seq[0] == 8'hF0) begin
      seq.delete();
      model_event(1'b0, b, 1'b0);
    end else if (seq.size() == 2 && b == 8'hF0) begin
      return;
    end else begin
      brk = (seq.size() == 3);
      seq.delete();
      if (!(b == 8'h12 || b == 8'h59)) model_event(1'b1, b, !brk);
    end
  endtask

  // Accept / event monitors
  int cyc = 0;
  int last_acc = -100;
  int accepts = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_valid && bus.rx_ready) begin
      last_acc <= cyc;
      accepts  <= accepts + 1;
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    int pending;
    if (!reset && key_event) begin
      pending = exp_q.size();
      check_eq("event_expected", pending > 0, 1);
      if (pending > 0) begin
        e = exp_q.pop_front();
        check_eq("key_code", key_code, e[8:0]);
        check_eq("key_make", key_make, e[9]);
        check_eq("event_latency", cyc - last_acc, 3);
      end
    end
  end

  // Stimulus helpers
  task automatic wait_ready();
    int n = 0;
    while (!bus.rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("rx_ready_timeout", n, 0);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    wait_ready();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    model_byte(b);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic map_write(input logic [8:0] a, input logic [1:0] k, input int r, input int c);
    @(negedge clk);
    bus.map_we    = 1'b1;
    bus.map_addr  = a;
    bus.map_wdata = {k, 3'(r), 3'(c)};
    m_kind[a] = k;
    m_row[a]  = r;
    m_col[a]  = c;
    @(negedge clk);
    bus.map_we = 1'b0;
  endtask

  task automatic check_outputs(input logic [ROWS-1:0] s);
    logic [COLS-1:0] e_hi, e_lo, e_al;
    logic [NMOD-1:0] e_mods_al;
    @(negedge clk);
    wait_ready();
    sel = s;
    #1;
    e_hi = '0;
    e_lo = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (s[r]) e_hi = e_hi | m_mat[r];
      else      e_lo = e_lo | m_mat[r];
    end
    e_al      = ~e_lo;
    e_mods_al = ~m_mods;
    check_eq("odata", odata, e_hi);
    check_eq("odata_al", odata_al, e_al);
    check_eq("mods", mods, m_mods);
    check_eq("mods_al", mods_al, e_mods_al);
  endtask

  task automatic do_reset();
    int n;
    int bad_ready;
    logic [COLS-1:0] all_cols;
    logic [NMOD-1:0] all_mods;
    all_cols = '1;
    all_mods = '1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    sel = '1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_key_event", key_event, 0);
    check_eq("rst_key_code", key_code, 0);
    check_eq("rst_key_make", key_make, 0);
    check_eq("rst_odata", odata, 0);
    check_eq("rst_odata_al", odata_al, all_cols);
    check_eq("rst_mods", mods, 0);
    check_eq("rst_mods_al", mods_al, all_mods);
    check_eq("rst_init_busy", bus.init_busy, 1);
    // This write lands during INIT and must be dropped.
    bus.map_we    = 1'b1;
    bus.map_addr  = 9'h01C;
    bus.map_wdata = {2'b01, 3'd1, 3'd4};
    reset = 1'b0;
    n = 0;
    bad_ready = 0;
    while (bus.init_busy && n < 600) begin
      @(negedge clk);
      n++;
      if (bus.init_busy && bus.rx_ready) bad_ready++;
    end
    bus.map_we = 1'b0;
    check_eq("init_cycles", n, 512);
    check_eq("ready_during_init", bad_ready, 0);
    check_eq("ready_after_init", bus.rx_ready, 1);
  endtask

  logic [7:0] pool [16];

  initial begin
    int acc0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.map_we    = 1'b0;
    bus.map_addr  = '0;
    bus.map_wdata = '0;
    sel           = '0;
    model_reset();

    do_reset();
    send(8'h1C);
    check_outputs(8'h02);

    map_write(9'h01C, 2'b01, 1, 4);
    send(8'h1C);
    check_outputs(8'h02);
    check_outputs(8'hFD);
    send(8'hF0); send(8'h1C);
    check_outputs(8'h02);

    map_write(9'h175, 2'b01, 5, 1);
    send(8'hE0); send(8'h75);
    check_outputs(8'h20);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
    check_outputs(8'h20);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_outputs(8'h20);

    map_write(9'h012, 2'b10, 0, 0);
    send(8'h12);
    send(8'h1C);
    check_outputs(8'h02);
    send(8'hAA);
    check_outputs(8'hFF);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1C);
    check_outputs(8'h02);

    // Hold rx_valid through LOOKUP and APPLY: only one accept.
    @(negedge clk);
    wait_ready();
    acc0 = accepts;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hF0;
    model_byte(8'hF0);
    @(negedge clk);
    bus.rx_data = 8'h1C;
    model_byte(8'h1C);
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_eq("held_valid_accepts", accepts - acc0, 2);
    check_outputs(8'h02);

    // Map write to the address being looked up returns the old entry.
    map_write(9'h014, 2'b01, 2, 3);
    @(negedge clk);
    wait_ready();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h14;
    model_byte(8'h14);
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.map_we    = 1'b1;
    bus.map_addr  = 9'h014;
    bus.map_wdata = {2'b01, 3'd6, 3'd6};
    m_kind[9'h014] = 2'b01;
    m_row[9'h014]  = 6;
    m_col[9'h014]  = 6;
    @(negedge clk);
    bus.map_we = 1'b0;
    check_outputs(8'h04);
    send(8'hF0); send(8'h14);
    check_outputs(8'h44);

    // Reset mid-sequence drops the E0 F0 prefix.
    send(8'hE0); send(8'hF0);
    do_reset();
    map_write(9'h075, 2'b01, 3, 0);
    send(8'h75);
    check_outputs(8'h08);

    // Randomized traffic
    pool = '{8'h1C, 8'h75, 8'h12, 8'h59, 8'h14, 8'h77, 8'hF0, 8'hF0,
             8'hE0, 8'hE0, 8'h1B, 8'h23, 8'hE1, 8'hAA, 8'hFA, 8'h1C};
    for (int i = 0; i < 12; i++) begin
      map_write({1'($urandom), pool[$urandom_range(0, 15)]}, 2'($urandom),
                $urandom_range(0, 7), $urandom_range(0, 7));
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        map_write({1'($urandom), pool[$urandom_range(0, 15)]}, 2'($urandom),
                  $urandom_range(0, 7), $urandom_range(0, 7));
      end
      send(pool[$urandom_range(0, 15)]);
      check_outputs(ROWS'($urandom));
    end

    repeat (5) @(negedge clk);
    check_eq("events_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
